instr_exec_unit: RTL and testbench

Execution stage directly downstream of instr_register. On a start command it walks a contiguous range of register locations by driving read_pointer, evaluates each returned instruction_word (opcode applied to operand_a/operand_b), and presents one result per instruction on a valid/ready output port. It is the producer the self-checking scoreboard compares against.

---
 rtl/instr_register_pkg.sv | 41 ++++
 rtl/instr_alu.sv | 45 ++++
 rtl/instr_exec_unit.sv | 113 +++++++++++
 tb/tb_instr_exec_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its execution stage.
// Adds the 64-bit signed result type and the exec FSM state enum.
package instr_register_pkg;

  localparam int NUM_REGS = 32;
  localparam int COUNT_W  = 6;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } exec_state_t;

  // Widen an operand to result width, preserving its sign.
  function automatic result_t sext(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational evaluator for one instruction_t.
// Optional macro EXEC_DIV_EN: when defined, DIV/MOD are real divides;
// when undefined, no divider exists and DIV/MOD report div_zero.
import instr_register_pkg::*;

module instr_alu (
  input  instruction_t instr,
  output result_t      result,
  output logic         div_zero
);

  result_t a;
  result_t b;

  // Operands are sign-extended first, so 64-bit arithmetic cannot overflow.
  always_comb begin
    a        = sext(instr.op_a);
    b        = sext(instr.op_b);
    result   = '0;
    div_zero = 1'b0;
    case (instr.opc)
      ZERO:  result = '0;
      PASSA: result = a;
      PASSB: result = b;
      ADD:   result = a + b;
      SUB:   result = a - b;
      MULT:  result = a * b;
      DIV, MOD: begin
`ifdef EXEC_DIV_EN
        if (b == '0) begin
          div_zero = 1'b1;
        end else if (instr.opc == DIV) begin
          result = a / b;
        end else begin
          result = a % b;
        end
`else
        div_zero = 1'b1;
`endif
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a range of instr_register locations, evaluates
// each instruction and emits one result per instruction on valid/ready.
// DIV/MOD behaviour depends on macro EXEC_DIV_EN (see instr_alu).
import instr_register_pkg::*;

module instr_exec_unit (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_addr,
  input  logic [5:0]   count,
  output logic         busy,
  output logic         done,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         result_valid,
  input  logic         result_ready,
  output result_t      result,
  output address_t     result_addr,
  output opcode_t      result_opc,
  output logic         div_zero
);

  exec_state_t          state_reg;
  exec_state_t          state_next;
  logic [COUNT_W-1:0]   remaining_reg;
  logic                 launch;
  logic                 empty_start;
  logic                 capture;
  logic                 finish;
  result_t              alu_result;
  logic                 alu_div_zero;

  instr_alu u_alu (
    .instr    (instruction_word),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  assign busy = (state_reg != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next  = state_reg;
    launch      = 1'b0;
    empty_start = 1'b0;
    capture     = 1'b0;
    finish      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            empty_start = 1'b1;
          end else begin
            launch     = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        // Output register is free when empty or being drained this cycle.
        if (!result_valid || result_ready) begin
          capture = 1'b1;
          if (remaining_reg == 6'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (result_valid && result_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address counter, remaining count and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_reg <= '0;
      read_pointer  <= '0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      result        <= '0;
      result_addr   <= '0;
      result_opc    <= ZERO;
      div_zero      <= 1'b0;
    end else begin
      done <= finish | empty_start;
      if (launch) begin
        read_pointer  <= first_addr;
        remaining_reg <= count;
      end
      if (capture) begin
        result        <= alu_result;
        div_zero      <= alu_div_zero;
        result_addr   <= read_pointer;
        result_opc    <= instruction_word.opc;
        result_valid  <= 1'b1;
        read_pointer  <= read_pointer + 5'd1;
        remaining_reg <= remaining_reg - 6'd1;
      end
      if (finish) result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit with a combinational
// instr_register model. Expectations follow EXEC_DIV_EN when defined.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  address_t     first_addr = '0;
  logic [5:0]   count = '0;
  logic         busy;
  logic         done;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         result_valid;
  logic         result_ready = 1'b1;
  result_t      result;
  address_t     result_addr;
  opcode_t      result_opc;
  logic         div_zero;

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result           (result),
    .result_addr      (result_addr),
    .result_opc       (result_opc),
    .div_zero         (div_zero)
  );

  always #5 clk = ~clk;

  instruction_t mem [NUM_REGS];
  assign instruction_word = mem[read_pointer];

  int total = 0;
  int bad   = 0;

  // Per-run log, filled by run_job.
  logic     cyc_valid [64];
  logic     cyc_busy  [64];
  result_t  cyc_res   [64];
  address_t cyc_addr  [64];
  result_t  acc_res  [$];
  address_t acc_addr [$];
  opcode_t  acc_opc  [$];
  logic     acc_dz   [$];
  int       acc_cyc  [$];
  int       done_cyc;

  // Start a job, then sample once per cycle (cycle 0 = after the start edge).
  // stall[k] drops result_ready in cycle k; inject_cyc pulses a stray start.
  task automatic run_job(input address_t fa, input logic [5:0] cnt,
                         input logic [63:0] stall, input int inject_cyc,
                         input int budget);
    acc_res.delete(); acc_addr.delete(); acc_opc.delete();
    acc_dz.delete(); acc_cyc.delete();
    done_cyc = -1;
    for (int k = 0; k < 64; k++) begin
      cyc_valid[k] = 1'b0; cyc_busy[k] = 1'b0;
      cyc_res[k] = '0; cyc_addr[k] = '0;
    end
    @(negedge clk);
    start = 1'b1; first_addr = fa; count = cnt;
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      @(negedge clk);
      start = (k == inject_cyc);
      if (start) begin
        first_addr = fa + 5'd10;
        count      = 6'd1;
      end
      result_ready = !stall[k];
      #1;
      cyc_valid[k] = result_valid; cyc_busy[k] = busy;
      cyc_res[k] = result; cyc_addr[k] = result_addr;
      if (result_valid && result_ready) begin
        acc_res.push_back(result); acc_addr.push_back(result_addr);
        acc_opc.push_back(result_opc); acc_dz.push_back(div_zero);
        acc_cyc.push_back(k);
        $display("  accept cyc=%0d addr=%0d opc=%s result=%0d div_zero=%0b",
                 k, result_addr, result_opc.name(), result, div_zero);
      end
      if (done) done_cyc = k;
    end
    start = 1'b0;
    result_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({busy, done, result_valid, div_zero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, result_valid, div_zero});
    end
    total++; if (read_pointer !== 5'd0 || result_addr !== 5'd0) begin
      bad++; $display("FAIL reset_addr got rp=%0d ra=%0d want 0/0", read_pointer, result_addr);
    end
    total++; if (result !== 64'sd0 || result_opc !== ZERO) begin
      bad++; $display("FAIL reset_result got=%0d opc=%0d want 0/ZERO", result, result_opc);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    result_t  er [3] = '{64'sd12, -64'sd13, -64'sd18};
    address_t ea [3] = '{5'd3, 5'd4, 5'd5};
    opcode_t  eo [3] = '{ADD, SUB, MULT};
    run_job(5'd3, 6'd3, 64'd0, -1, 20);
    total++; if (cyc_busy[0] !== 1'b1 || cyc_valid[0] !== 1'b0) begin
      bad++; $display("FAIL basic_cycle0 got busy=%b valid=%b want 1/0", cyc_busy[0], cyc_valid[0]);
    end
    total++; if (acc_res.size() != 3) begin
      bad++; $display("FAIL basic_count got=%0d want=3", acc_res.size());
    end
    for (int i = 0; i < 3 && i < acc_res.size(); i++) begin
      total++; if (acc_res[i] !== er[i] || acc_addr[i] !== ea[i] || acc_opc[i] !== eo[i] || acc_dz[i] !== 1'b0) begin
        bad++; $display("FAIL basic_result%0d got=%0d@%0d opc=%0d dz=%b want=%0d@%0d opc=%0d dz=0",
                        i, acc_res[i], acc_addr[i], acc_opc[i], acc_dz[i], er[i], ea[i], eo[i]);
      end
      total++; if (acc_cyc[i] != i + 1) begin
        bad++; $display("FAIL basic_timing%0d got=%0d want=%0d", i, acc_cyc[i], i + 1);
      end
    end
    total++; if (done_cyc != 4) begin
      bad++; $display("FAIL basic_done got=%0d want=4", done_cyc);
    end
  endtask

  task automatic test_wrap();
    address_t ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    result_t  er [4] = '{64'sd1030, 64'sd1031, 64'sd1000, 64'sd1001};
    run_job(5'd30, 6'd4, 64'd0, -1, 20);
    total++; if (acc_res.size() != 4 || done_cyc != 5) begin
      bad++; $display("FAIL wrap_count got=%0d done=%0d want=4 done=5", acc_res.size(), done_cyc);
    end
    for (int i = 0; i < 4 && i < acc_res.size(); i++) begin
      total++; if (acc_addr[i] !== ea[i] || acc_res[i] !== er[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%0d val=%0d want=%0d val=%0d", i, acc_addr[i], acc_res[i], ea[i], er[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    result_t er [3] = '{64'sd12, -64'sd13, -64'sd18};
    int      ec [3] = '{1, 4, 5};
    run_job(5'd3, 6'd3, 64'hC, -1, 20);
    for (int k = 2; k <= 4; k++) begin
      total++; if (cyc_valid[k] !== 1'b1 || cyc_res[k] !== -64'sd13 || cyc_addr[k] !== 5'd4) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b %0d@%0d want v=1 -13@4", k, cyc_valid[k], cyc_res[k], cyc_addr[k]);
      end
    end
    total++; if (acc_res.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d want=3", acc_res.size());
    end
    for (int i = 0; i < 3 && i < acc_res.size(); i++) begin
      total++; if (acc_res[i] !== er[i] || acc_cyc[i] != ec[i]) begin
        bad++; $display("FAIL bp_result%0d got=%0d cyc=%0d want=%0d cyc=%0d", i, acc_res[i], acc_cyc[i], er[i], ec[i]);
      end
    end
    total++; if (done_cyc != 6) begin
      bad++; $display("FAIL bp_done got=%0d want=6", done_cyc);
    end
  endtask

  task automatic test_divide();
`ifdef EXEC_DIV_EN
    result_t er [3] = '{-64'sd3, -64'sd1, 64'sd0};
    logic    ed [3] = '{1'b0, 1'b0, 1'b1};
`else
    result_t er [3] = '{64'sd0, 64'sd0, 64'sd0};
    logic    ed [3] = '{1'b1, 1'b1, 1'b1};
`endif
    run_job(5'd10, 6'd3, 64'd0, -1, 20);
    total++; if (acc_res.size() != 3) begin
      bad++; $display("FAIL div_count got=%0d want=3", acc_res.size());
    end
    for (int i = 0; i < 3 && i < acc_res.size(); i++) begin
      total++; if (acc_res[i] !== er[i] || acc_dz[i] !== ed[i]) begin
        bad++; $display("FAIL div_result%0d got=%0d dz=%b want=%0d dz=%b", i, acc_res[i], acc_dz[i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_count_zero();
    run_job(5'd7, 6'd0, 64'd0, -1, 6);
    total++; if (done_cyc != 0) begin
      bad++; $display("FAIL zero_done got=%0d want=0", done_cyc);
    end
    total++; if (cyc_busy[0] !== 1'b0 || cyc_valid[0] !== 1'b0 || acc_res.size() != 0) begin
      bad++; $display("FAIL zero_idle got busy=%b valid=%b n=%0d want 0/0/0", cyc_busy[0], cyc_valid[0], acc_res.size());
    end
  endtask

  task automatic test_busy_start();
    // Stray start mid-run, then a stray start on the final acceptance edge.
    for (int r = 0; r < 2; r++) begin
      run_job(5'd3, 6'd3, 64'd0, (r == 0) ? 1 : 3, 20);
      total++; if (acc_res.size() != 3 || done_cyc != 4) begin
        bad++; $display("FAIL busy_run%0d got n=%0d done=%0d want n=3 done=4", r, acc_res.size(), done_cyc);
      end else begin
        total++; if (acc_addr[0] !== 5'd3 || acc_addr[2] !== 5'd5 || acc_res[1] !== -64'sd13) begin
          bad++; $display("FAIL busy_data%0d got %0d,%0d,%0d want 3,-13,5", r, acc_addr[0], acc_res[1], acc_addr[2]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
          bad++; $display("FAIL busy_after%0d got busy=%b valid=%b want 0/0", r, busy, result_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; first_addr = 5'd3; count = 6'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1 || result_valid !== 1'b1) begin
      bad++; $display("FAIL rst_prerun got busy=%b valid=%b want 1/1", busy, result_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({busy, done, result_valid, div_zero} !== 4'b0000 || read_pointer !== 5'd0) begin
      bad++; $display("FAIL rst_async got flags=%b rp=%0d want 0000/0", {busy, done, result_valid, div_zero}, read_pointer);
    end
    total++; if (result !== 64'sd0 || result_addr !== 5'd0 || result_opc !== ZERO) begin
      bad++; $display("FAIL rst_async_data got=%0d@%0d opc=%0d want 0@0 ZERO", result, result_addr, result_opc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL rst_idle got busy=%b valid=%b want 0/0", busy, result_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};
    mem[3]  = '{opc: ADD,   op_a: 32'sd5,  op_b: 32'sd7};
    mem[4]  = '{opc: SUB,   op_a: -32'sd4, op_b: 32'sd9};
    mem[5]  = '{opc: MULT,  op_a: -32'sd3, op_b: 32'sd6};
    mem[10] = '{opc: DIV,   op_a: -32'sd7, op_b: 32'sd2};
    mem[11] = '{opc: MOD,   op_a: -32'sd7, op_b: 32'sd2};
    mem[12] = '{opc: DIV,   op_a: 32'sd9,  op_b: 32'sd0};
    mem[30] = '{opc: PASSA, op_a: 32'sd1030, op_b: 32'sd1};
    mem[31] = '{opc: PASSA, op_a: 32'sd1031, op_b: 32'sd1};
    mem[0]  = '{opc: PASSA, op_a: 32'sd1000, op_b: 32'sd1};
    mem[1]  = '{opc: PASSA, op_a: 32'sd1001, op_b: 32'sd1};

    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_divide();
    test_count_zero();
    test_busy_start();
    test_reset_mid_run();
    test_basic();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
